sr_input_conditioner: RTL and testbench

SR_INPUT_CONDITIONER -- requirements
Module: sr_input_conditioner

---
 rtl/sr_cond_pkg.sv | 19 +
 rtl/sr_debounce_ch.sv | 72 +++++++
 rtl/sr_input_conditioner.sv | 128 ++++++++++++
 tb/tb_sr_input_conditioner.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_cond_pkg.sv
// -----------------------------------------------------------------------------
// sr_cond_pkg
// Shared types and constants for the SR input conditioner.
//   CNT_W      : width of the 8-bit debounce and pulse-length counters
//   sr_state_t : pulse generator FSM states
// Build option: SR_COND_RESET_PRIORITY_EN (see sr_input_conditioner.sv).
// -----------------------------------------------------------------------------
package sr_cond_pkg;

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE_S = 2'd1,
        PULSE_R = 2'd2,
        GAP     = 2'd3
    } sr_state_t;

endpackage

// File: rtl/sr_debounce_ch.sv
// -----------------------------------------------------------------------------
// sr_debounce_ch
// One input channel: 2-flop synchronizer, debounce counter and falling-edge
// request detection for an active-low, bouncy, asynchronous request line.
// Ports:
//   clk      in  : clock, rising edge
//   rst_n    in  : asynchronous active-low reset
//   i_raw_n  in  : raw asynchronous active-low request
//   o_fall   out : registered one-cycle pulse on a 1->0 debounced transition
// Build option: none (SR_COND_RESET_PRIORITY_EN only affects the top).
// -----------------------------------------------------------------------------
module sr_debounce_ch
    import sr_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
)(
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw_n,
    output logic o_fall
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_armed;
    logic             r_fall;
    logic [1:0]       r_warm;
    logic [CNT_W-1:0] r_cnt;

    // r_warm marks the point where r_sync2 carries a real post-reset sample
    // instead of the synchronizer's reset value. The channel only arms once
    // such a real sample shows the line released while the level is high, so
    // a line held low across reset cannot produce a request until it has been
    // released and pressed again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_armed <= 1'b0;
            r_fall  <= 1'b0;
            r_warm  <= 2'b00;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw_n;
            r_sync2 <= r_sync1;
            r_warm  <= {r_warm[0], 1'b1};
            r_fall  <= 1'b0;

            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == DEB_LAST) begin
                // This is the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_fall  <= r_armed & ~r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (r_warm[1] && r_level && r_sync2) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign o_fall = r_fall;

endmodule

// File: rtl/sr_input_conditioner.sv
// -----------------------------------------------------------------------------
// sr_input_conditioner
// Conditions two bouncy active-low requests into clean, mutually exclusive
// active-low set/reset pulses for a downstream SR latch.
// Ports:
//   clk          in  : clock, rising edge
//   rst_n        in  : asynchronous active-low reset
//   s_raw_n      in  : raw active-low set request
//   r_raw_n      in  : raw active-low reset request
//   s_n          out : registered active-low set pulse (PULSE_CYCLES long)
//   r_n          out : registered active-low reset pulse (PULSE_CYCLES long)
//   conflict     out : registered one-cycle pulse when both requests collide
//   busy         out : high whenever the FSM is not IDLE
//   o_dbg_state  out : current FSM state encoding
// Build option: SR_COND_RESET_PRIORITY_EN -- when defined, colliding requests
// are resolved in favour of reset (a reset pulse is issued); when undefined,
// both requests are discarded and only conflict pulses.
// -----------------------------------------------------------------------------
module sr_input_conditioner
    import sr_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned PULSE_CYCLES    = 3
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_raw_n,
    input  logic       r_raw_n,
    output logic       s_n,
    output logic       r_n,
    output logic       conflict,
    output logic       busy,
    output logic [1:0] o_dbg_state
);

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);

    logic             w_fall_s;
    logic             w_fall_r;
    sr_state_t        r_state;
    logic             r_pend_s;
    logic             r_pend_r;
    logic [CNT_W-1:0] r_cnt;
    logic             r_s_n;
    logic             r_r_n;
    logic             r_conflict;

    sr_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch_s (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raw_n (s_raw_n),
        .o_fall  (w_fall_s)
    );

    sr_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch_r (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raw_n (r_raw_n),
        .o_fall  (w_fall_r)
    );

    // Pending flags accumulate new requests every cycle; a served channel is
    // cleared on entry, but a request arriving on that same edge is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pend_s   <= 1'b0;
            r_pend_r   <= 1'b0;
            r_cnt      <= '0;
            r_s_n      <= 1'b1;
            r_r_n      <= 1'b1;
            r_conflict <= 1'b0;
        end else begin
            r_conflict <= 1'b0;
            r_pend_s   <= r_pend_s | w_fall_s;
            r_pend_r   <= r_pend_r | w_fall_r;

            case (r_state)
                IDLE: begin
                    if (r_pend_s && r_pend_r) begin
                        r_conflict <= 1'b1;
                        r_pend_s   <= w_fall_s;
                        r_pend_r   <= w_fall_r;
`ifdef SR_COND_RESET_PRIORITY_EN
                        r_state    <= PULSE_R;
                        r_r_n      <= 1'b0;
                        r_cnt      <= PULSE_LAST;
`endif
                    end else if (r_pend_s) begin
                        r_state  <= PULSE_S;
                        r_s_n    <= 1'b0;
                        r_cnt    <= PULSE_LAST;
                        r_pend_s <= w_fall_s;
                    end else if (r_pend_r) begin
                        r_state  <= PULSE_R;
                        r_r_n    <= 1'b0;
                        r_cnt    <= PULSE_LAST;
                        r_pend_r <= w_fall_r;
                    end
                end
                PULSE_S, PULSE_R: begin
                    if (r_cnt == '0) begin
                        r_state <= GAP;
                        r_s_n   <= 1'b1;
                        r_r_n   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                GAP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_s_n   <= 1'b1;
                    r_r_n   <= 1'b1;
                end
            endcase
        end
    end

    assign s_n         = r_s_n;
    assign r_n         = r_r_n;
    assign conflict    = r_conflict;
    assign busy        = (r_state != IDLE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sr_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_sr_input_conditioner
// Bench for sr_input_conditioner. A reference model derives, from the raw
// input history, when each set/reset pulse and conflict pulse must start; a
// monitor compares what the DUT presents against those expectations.
// -----------------------------------------------------------------------------
module tb_sr_input_conditioner;

    localparam int D    = 4;
    localparam int P    = 3;
    localparam int HMAX = 8192;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       s_raw_n = 1'b0;
    logic       r_raw_n = 1'b0;
    logic       s_n;
    logic       r_n;
    logic       conflict;
    logic       busy;
    logic [1:0] dbg_state;

    int checks   = 0;
    int failures = 0;

    sr_input_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .PULSE_CYCLES    (P)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_raw_n     (s_raw_n),
        .r_raw_n     (r_raw_n),
        .s_n         (s_n),
        .r_n         (r_n),
        .conflict    (conflict),
        .busy        (busy),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Synchronized sample k after reset release is the raw value seen at edge
    // k-2 (the first two samples are the synchronizer's reset value of 1).
    // A debounced level flips when its last D synchronized samples all differ
    // from it. A falling flip on an armed channel becomes pending two edges
    // later; the pulse server starts one job per IDLE edge, each job taking
    // P low cycles, one GAP cycle, and one IDLE cycle before the next start.
    int  cyc = 0;
    int  k   = 0;
    bit  hist [2][HMAX];
    bit  level [2];
    bit  armed [2];
    bit  flip_prev [2];
    bit  pend [2];
    bit  raw_now [2];
    bit  cur, fl, arm_n;
    int  next_free = 0;
    int  busy_last = -1;
    bit  exp_busy  = 1'b0;
    logic [31:0] exp_s_q[$];
    logic [31:0] exp_r_q[$];
    logic [31:0] exp_c_q[$];

    function automatic bit sync_at(int ch, int j);
        if (j < 2) return 1'b1;
        return hist[ch][j-2];
    endfunction

    function automatic bit window_flips(int ch, int kk);
        for (int j = kk - D + 1; j <= kk; j++) begin
            if (sync_at(ch, j) == level[ch]) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            k         = 0;
            next_free = 0;
            busy_last = -1;
            exp_busy  = 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                level[ch]     = 1'b1;
                armed[ch]     = 1'b0;
                flip_prev[ch] = 1'b0;
                pend[ch]      = 1'b0;
            end
            exp_s_q.delete();
            exp_r_q.delete();
            exp_c_q.delete();
        end else begin
            if (cyc >= next_free) begin
                if (pend[0] && pend[1]) begin
                    exp_c_q.push_back(cyc);
`ifdef SR_COND_RESET_PRIORITY_EN
                    exp_r_q.push_back(cyc);
                    busy_last = cyc + P;
                    next_free = cyc + P + 2;
`endif
                    pend[0] = 1'b0;
                    pend[1] = 1'b0;
                end else if (pend[0]) begin
                    exp_s_q.push_back(cyc);
                    pend[0]   = 1'b0;
                    busy_last = cyc + P;
                    next_free = cyc + P + 2;
                end else if (pend[1]) begin
                    exp_r_q.push_back(cyc);
                    pend[1]   = 1'b0;
                    busy_last = cyc + P;
                    next_free = cyc + P + 2;
                end
            end
            exp_busy = (cyc <= busy_last);
            for (int ch = 0; ch < 2; ch++) begin
                if (flip_prev[ch]) pend[ch] = 1'b1;
            end
            raw_now[0] = s_raw_n;
            raw_now[1] = r_raw_n;
            if (k < HMAX) begin
                for (int ch = 0; ch < 2; ch++) begin
                    hist[ch][k] = raw_now[ch];
                    cur   = sync_at(ch, k);
                    fl    = 1'b0;
                    arm_n = armed[ch] || (k >= 2 && cur && level[ch]);
                    if (k >= D - 1 && window_flips(ch, k)) begin
                        level[ch] = ~level[ch];
                        fl        = armed[ch] && !level[ch];
                    end
                    armed[ch]     = arm_n;
                    flip_prev[ch] = fl;
                end
                k++;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    bit          s_act = 1'b0;
    bit          r_act = 1'b0;
    bit          c_prev = 1'b0;
    int          s_start, s_len, r_start, r_len;
    logic [31:0] e;

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            s_act  = 1'b0;
            r_act  = 1'b0;
            c_prev = 1'b0;
        end else begin
            checks++;
            if (busy !== exp_busy) begin
                failures++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
            end
            if (s_n === 1'b0 && r_n === 1'b0) begin
                checks++;
                failures++;
                $display("FAIL overlap cyc=%0d s_n=0 r_n=0 exp at most one low", cyc);
            end

            if (s_n === 1'b0) begin
                if (!s_act) begin
                    s_act   = 1'b1;
                    s_start = cyc;
                    s_len   = 0;
                end
                s_len++;
            end else if (s_act) begin
                s_act = 1'b0;
                checks++;
                if (exp_s_q.size() == 0) begin
                    failures++;
                    $display("FAIL s_pulse unexpected start=%0d len=%0d exp none", s_start, s_len);
                end else begin
                    e = exp_s_q.pop_front();
                    if (e != 32'(s_start) || s_len != P) begin
                        failures++;
                        $display("FAIL s_pulse got start=%0d len=%0d exp start=%0d len=%0d",
                                 s_start, s_len, e, P);
                    end
                end
            end

            if (r_n === 1'b0) begin
                if (!r_act) begin
                    r_act   = 1'b1;
                    r_start = cyc;
                    r_len   = 0;
                end
                r_len++;
            end else if (r_act) begin
                r_act = 1'b0;
                checks++;
                if (exp_r_q.size() == 0) begin
                    failures++;
                    $display("FAIL r_pulse unexpected start=%0d len=%0d exp none", r_start, r_len);
                end else begin
                    e = exp_r_q.pop_front();
                    if (e != 32'(r_start) || r_len != P) begin
                        failures++;
                        $display("FAIL r_pulse got start=%0d len=%0d exp start=%0d len=%0d",
                                 r_start, r_len, e, P);
                    end
                end
            end

            if (conflict === 1'b1) begin
                checks++;
                if (c_prev) begin
                    failures++;
                    $display("FAIL conflict_len cyc=%0d got high 2+ cycles exp 1", cyc);
                end else if (exp_c_q.size() == 0) begin
                    failures++;
                    $display("FAIL conflict unexpected cyc=%0d exp none", cyc);
                end else begin
                    e = exp_c_q.pop_front();
                    if (e != 32'(cyc)) begin
                        failures++;
                        $display("FAIL conflict got cyc=%0d exp cyc=%0d", cyc, e);
                    end
                end
            end
            c_prev = (conflict === 1'b1);
        end
    end

    // ---------------- driver helpers ----------------
    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%b exp=%b", name, $time, got, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    int hold_s, hold_r, n, low_cnt;

    initial begin
        // Reset with both raw inputs held low.
        rst_n   = 1'b0;
        s_raw_n = 1'b0;
        r_raw_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_bit("rst_s_n", s_n, 1'b1);
        check_bit("rst_r_n", r_n, 1'b1);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_conflict", conflict, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_neg(20);
        s_raw_n = 1'b1;
        r_raw_n = 1'b1;
        wait_neg(20);

        // Clean set: s_n low on edges D+3..D+2+P, busy through the GAP edge.
        s_raw_n = 1'b0;
        for (int i = 0; i <= 12; i++) begin
            @(posedge clk);
            #1;
            check_bit("clean_s_n", s_n, !(i >= D + 3 && i <= D + 2 + P));
            check_bit("clean_r_n", r_n, 1'b1);
            check_bit("clean_busy", busy, (i >= D + 3 && i <= D + 3 + P));
        end
        @(negedge clk);
        s_raw_n = 1'b1;
        wait_neg(20);

        // Bounce: 2-cycle segments never survive the debounce window.
        for (int i = 0; i < 10; i++) begin
            s_raw_n = (i % 2 == 1);
            wait_neg(2);
        end
        s_raw_n = 1'b1;
        wait_neg(30);

        // Back-to-back set then reset two cycles later.
        s_raw_n = 1'b0;
        wait_neg(2);
        r_raw_n = 1'b0;
        wait_neg(25);
        s_raw_n = 1'b1;
        r_raw_n = 1'b1;
        wait_neg(30);

        // Simultaneous falling requests.
        s_raw_n = 1'b0;
        r_raw_n = 1'b0;
        wait_neg(20);
        s_raw_n = 1'b1;
        r_raw_n = 1'b1;
        wait_neg(30);

        // Random independent activity on both channels.
        hold_s = 1;
        hold_r = 1;
        repeat (600) begin
            @(negedge clk);
            hold_s = hold_s - 1;
            if (hold_s == 0) begin
                s_raw_n = ~s_raw_n;
                hold_s  = $urandom_range(1, 10);
            end
            hold_r = hold_r - 1;
            if (hold_r == 0) begin
                r_raw_n = ~r_raw_n;
                hold_r  = $urandom_range(1, 10);
            end
        end
        s_raw_n = 1'b1;
        r_raw_n = 1'b1;
        wait_neg(40);

        // Reset during the second PULSE_S cycle.
        s_raw_n = 1'b0;
        n = 0;
        while (s_n !== 1'b0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 40) begin
            failures++;
            $display("FAIL midrst_wait got no s_n pulse within 40 cycles exp pulse");
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_bit("midrst_s_n", s_n, 1'b1);
        check_bit("midrst_r_n", r_n, 1'b1);
        check_bit("midrst_busy", busy, 1'b0);
        wait_neg(3);
        rst_n = 1'b1;
        low_cnt = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (s_n === 1'b0) low_cnt++;
        end
        checks++;
        if (low_cnt != 0) begin
            failures++;
            $display("FAIL midrst_held got %0d low cycles exp 0", low_cnt);
        end
        @(negedge clk);
        s_raw_n = 1'b1;
        wait_neg(15);
        s_raw_n = 1'b0;
        wait_neg(20);
        s_raw_n = 1'b1;
        wait_neg(30);

        // Everything the model expected must have appeared.
        checks++;
        if (exp_s_q.size() != 0) begin
            failures++;
            $display("FAIL s_drain got %0d missing pulses exp 0", exp_s_q.size());
        end
        checks++;
        if (exp_r_q.size() != 0) begin
            failures++;
            $display("FAIL r_drain got %0d missing pulses exp 0", exp_r_q.size());
        end
        checks++;
        if (exp_c_q.size() != 0) begin
            failures++;
            $display("FAIL c_drain got %0d missing conflicts exp 0", exp_c_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
